// File: rtl/irrigation_display_if.sv
// Irrigation code input plus multiplexed display and status outputs.
// master drives the code, slave is the decoder.
interface irrigation_display_if;
  logic [1:0] irrigation_encoded;
  logic [6:0] segments;
  logic [3:0] digit_select;
  logic       dripper_active;
  logic       sprinkler_active;
  logic       fault;

  modport master (
    output irrigation_encoded,
    input  segments,
    input  digit_select,
    input  dripper_active,
    input  sprinkler_active,
    input  fault
  );

  modport slave (
    input  irrigation_encoded,
    output segments,
    output digit_select,
    output dripper_active,
    output sprinkler_active,
    output fault
  );
endinterface

// File: rtl/irrigation_display_decoder.sv
// Debounces the 2-bit irrigation code into a mode FSM and drives a
// 4-digit multiplexed 7-segment display with a blinking fault message.
module irrigation_display_decoder #(
  parameter int SCAN_DIV      = 50000,
  parameter int STABLE_CYCLES = 4,
  parameter int BLINK_SCANS   = 64
) (
  input  logic clock,
  input  logic reset,
  irrigation_display_if.slave bus
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  typedef enum logic [1:0] {
    IDLE, DRIP, SPRK, FAULT
  } state_t;

  state_t        state, state_next;
  logic [1:0]    cand;
  logic [CW-1:0] cnt, cnt_next;
  logic          commit;
  logic [PW-1:0] presc;
  logic          wrap;
  logic [1:0]    idx;
  logic [BW-1:0] bcnt;
  logic          phase;
  logic [6:0]    glyph;
  logic [6:0]    seg_d;
  logic [3:0]    ds_d;

  always_comb begin
    cnt_next = cnt;
    if (bus.irrigation_encoded != cand)
      cnt_next = CW'(1);
    else if (cnt < CW'(STABLE_CYCLES))
      cnt_next = cnt + CW'(1);
  end

  // commit lands on the same edge the count reaches the threshold
  assign commit = (cnt_next == CW'(STABLE_CYCLES));
  assign wrap   = (presc == PW'(SCAN_DIV - 1));

  always_comb begin
    state_next = state;
    if (commit) begin
      unique case (bus.irrigation_encoded)
        2'b00: state_next = IDLE;
        2'b10: state_next = DRIP;
        2'b01: state_next = SPRK;
        2'b11: state_next = FAULT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cand  <= 2'b00;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cand  <= bus.irrigation_encoded;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc <= '0;
      idx   <= 2'd0;
      bcnt  <= '0;
      phase <= 1'b1;
    end else begin
      presc <= wrap ? '0 : presc + PW'(1);
      idx   <= idx + 2'(wrap);
      // outside FAULT the blinker sits at its entry value
      if (state != FAULT) begin
        bcnt  <= '0;
        phase <= 1'b1;
      end else if (wrap) begin
        if (bcnt == BW'(BLINK_SCANS - 1)) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + BW'(1);
        end
      end
    end
  end

  always_comb begin
    glyph = 7'b1111111;
    unique case (state)
      IDLE: glyph = 7'b0111111;
      DRIP: begin
        unique case (idx)
          2'd0: glyph = 7'b1000010;
          2'd1: glyph = 7'b0100011;
          2'd2: glyph = 7'b0000111;
          2'd3: glyph = 7'b1111111;
        endcase
      end
      SPRK: begin
        unique case (idx)
          2'd0: glyph = 7'b0001000;
          2'd1: glyph = 7'b0010010;
          2'd2: glyph = 7'b0001100;
          2'd3: glyph = 7'b1111111;
        endcase
      end
      FAULT: begin
        unique case (idx)
          2'd0: glyph = 7'b0000110;
          2'd1: glyph = 7'b0101111;
          2'd2: glyph = 7'b0101111;
          2'd3: glyph = 7'b1111111;
        endcase
      end
    endcase
  end

  assign seg_d = (state == FAULT && !phase) ? 7'b1111111 : glyph;
  assign ds_d  = ~(4'b0001 << idx);

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.segments     <= 7'b1111111;
      bus.digit_select <= 4'b1111;
    end else begin
      bus.segments     <= seg_d;
      bus.digit_select <= ds_d;
    end
  end

  assign bus.dripper_active   = (state == DRIP);
  assign bus.sprinkler_active = (state == SPRK);
  assign bus.fault            = (state == FAULT);
endmodule
